if_id_reg: RTL and testbench
============================

IF_ID_REG -- requirements
Module: if_id_reg

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, PC width.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction width.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h00000013, bubble instruction (addi x0,x0,0).
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid_i  input  1  fetch offers pc_i/instr_i.
REQ-007 SHALL have port in_ready_o  output  1  stage can accept.
REQ-008 SHALL have port pc_i  input  ADDR_W  PC of fetched instruction.
REQ-009 SHALL have port instr_i  input  INSTR_W  fetched instruction.
REQ-010 SHALL have port flush_i  input  1  discard all held and incoming instructions (branch taken).
REQ-011 SHALL have port out_valid_o  output  1  decode-side instruction valid.
REQ-012 SHALL have port out_ready_i  input  1  decode (Imm_Gen/regfile side) consumes.
REQ-013 SHALL have port pc_o  output  ADDR_W  held PC.
REQ-014 SHALL have port instr_o  output  INSTR_W  held instruction, drives Imm_Gen instr_i.
REQ-015 SHALL have port stall_cnt_o  output  32  back-pressure cycle count.

Function
REQ-016 SHALL hold a main register (M) driving outputs and a one-entry skid register (S).
REQ-017 SHALL drive in_ready_o = !S.valid, registered only (no combinational path from out_ready_i).
REQ-018 SHALL accept on in_valid_i && in_ready_o; accepted data appears on outputs next cycle (latency 1) when M empty or M consumed that cycle.
REQ-019 SHALL, when accepting while M valid and not consumed, write the input into S.
REQ-020 SHALL, when M consumed (out_valid_o && out_ready_i) and S valid, move S into M and clear S the same edge.
REQ-021 SHALL, when M consumed, S valid, and input accepted same cycle, be impossible since in_ready_o=0 while S valid.
REQ-022 SHALL preserve program order; never drop, duplicate or reorder accepted instructions absent flush.
REQ-023 SHALL drive instr_o = NOP_INSTR and pc_o unchanged whenever out_valid_o=0.
REQ-024 SHALL, on flush_i=1, clear M.valid and S.valid at the edge, ignore in_valid_i that cycle; flush overrides accept and consume.
REQ-025 SHALL keep out_ready_i without effect when out_valid_o=0.
REQ-026 SHALL sustain one instruction per cycle with out_ready_i held 1.

Reset
REQ-027 SHALL on rst_i=1 at a clock edge set M.valid=0, S.valid=0, pc_o=0, instr_o=NOP_INSTR, in_ready_o=1, stall_cnt_o=0.
REQ-028 SHALL give rst_i priority over flush_i and all handshakes; reset mid-stream discards both entries.

Configuration
REQ-029 SHALL, with IF_ID_PERF_EN defined, increment stall_cnt_o each cycle out_valid_o=1 && out_ready_i=0, saturating at 32'hFFFFFFFF, not counting flush cycles.
REQ-030 SHALL, without IF_ID_PERF_EN, tie stall_cnt_o to 0 and infer no counter logic.

Verification
REQ-031 Reset: rst_i=1 two cycles -> out_valid_o=0, instr_o=32'h00000013, in_ready_o=1, stall_cnt_o=0.
REQ-032 Streaming: out_ready_i=1, feed PC 0x0,0x4,0x8 with instr A,B,C back-to-back -> outputs A@0x0,B@0x4,C@0x8 on consecutive cycles, one cycle after each input.
REQ-033 Back-pressure: M holds A@0x0, out_ready_i=0, offer B@0x4 -> B in S, in_ready_o=0 next cycle; raise out_ready_i -> A then B emitted, in_ready_o returns 1.
REQ-034 Flush: M=A, S=B, flush_i=1 with C offered -> next cycle out_valid_o=0, instr_o=NOP, in_ready_o=1, C never emitted.
REQ-035 Perf: IF_ID_PERF_EN defined, out_ready_i=0 for 5 cycles with out_valid_o=1 -> stall_cnt_o=5; undefined -> stall_cnt_o=0.
REQ-036 Reset mid-operation: M and S full, rst_i=1 with flush_i=1 and in_valid_i=1 -> all state cleared, nothing emitted afterward.

Source files
------------

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: a main entry driving decode plus a one-entry skid buffer,
// so in_ready_o is a pure register output. Define IF_ID_PERF_EN to enable the stall counter.
module if_id_reg #(
    parameter int unsigned      ADDR_W    = 64,
    parameter int unsigned      INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               flush_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [31:0]        stall_cnt_o
);

    logic               m_valid_q, m_valid_d;
    logic [ADDR_W-1:0]  m_pc_q,    m_pc_d;
    logic [INSTR_W-1:0] m_instr_q, m_instr_d;
    logic               s_valid_q, s_valid_d;
    logic [ADDR_W-1:0]  s_pc_q,    s_pc_d;
    logic [INSTR_W-1:0] s_instr_q, s_instr_d;

    logic accept;
    logic consume;

    assign in_ready_o  = !s_valid_q;
    assign out_valid_o = m_valid_q;
    assign pc_o        = m_pc_q;
    assign instr_o     = m_valid_q ? m_instr_q : NOP_INSTR;

    assign accept  = in_valid_i && in_ready_o;
    assign consume = m_valid_q && out_ready_i;

    // NOTE: every _d gets a default first so no path through this block can infer a latch.
    always_comb begin
        m_valid_d = m_valid_q;
        m_pc_d    = m_pc_q;
        m_instr_d = m_instr_q;
        s_valid_d = s_valid_q;
        s_pc_d    = s_pc_q;
        s_instr_d = s_instr_q;

        if (flush_i) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!m_valid_q || consume) begin
            // Main slot frees up: the skid entry is older than anything incoming.
            if (s_valid_q) begin
                m_valid_d = 1'b1;
                m_pc_d    = s_pc_q;
                m_instr_d = s_instr_q;
                s_valid_d = 1'b0;
            end else if (accept) begin
                m_valid_d = 1'b1;
                m_pc_d    = pc_i;
                m_instr_d = instr_i;
            end else begin
                m_valid_d = 1'b0;
            end
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_pc_d    = pc_i;
            s_instr_d = instr_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; payload registers need no
    // reset because the valid bits gate them, except m_pc_q which is visible on pc_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
            m_pc_q    <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
            m_pc_q    <= m_pc_d;
        end
        m_instr_q <= m_instr_d;
        s_pc_q    <= s_pc_d;
        s_instr_q <= s_instr_d;
    end

`ifdef IF_ID_PERF_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!flush_i && m_valid_q && !out_ready_i && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Directed self-checking bench for if_id_reg: scoreboard of accepted instructions
// compared in order at each decode-side consume, plus direct checks of reset/flush/stall state.
module tb_if_id_reg;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;
    localparam logic [31:0] NOP     = 32'h00000013;

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               in_valid_i;
    logic               in_ready_o;
    logic [ADDR_W-1:0]  pc_i;
    logic [INSTR_W-1:0] instr_i;
    logic               flush_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [ADDR_W-1:0]  pc_o;
    logic [INSTR_W-1:0] instr_o;
    logic [31:0]        stall_cnt_o;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    entry_t      sb[$];
    entry_t      exp_e;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_stall = 32'd0;

    if_id_reg #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .NOP_INSTR(NOP)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .pc_i        (pc_i),
        .instr_i     (instr_i),
        .flush_i     (flush_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .pc_o        (pc_o),
        .instr_o     (instr_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scores the cycle about to end against the current inputs, then advances one clock.
    task automatic tick();
        if (rst_i) begin
            sb.delete();
            exp_stall = 32'd0;
        end else if (flush_i) begin
            sb.delete();
        end else begin
            if (out_valid_o && out_ready_i) begin
                check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    exp_e = sb.pop_front();
                    check("sb_pc", pc_o, exp_e.pc);
                    check("sb_instr", 64'(instr_o), 64'(exp_e.instr));
                end
            end
            if (out_valid_o && !out_ready_i && exp_stall != 32'hFFFF_FFFF) exp_stall++;
            if (in_valid_i && in_ready_o) sb.push_back('{pc: pc_i, instr: instr_i});
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic offer(input logic [ADDR_W-1:0] pc, input logic [INSTR_W-1:0] instr);
        in_valid_i = 1'b1;
        pc_i       = pc;
        instr_i    = instr;
    endtask

    function automatic logic [31:0] stall_exp();
`ifdef IF_ID_PERF_EN
        return exp_stall;
`else
        return 32'd0;
`endif
    endfunction

    initial begin
        rst_i = 1'b1; in_valid_i = 1'b0; pc_i = '0; instr_i = '0;
        flush_i = 1'b0; out_ready_i = 1'b0;
        #1;
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_instr",     64'(instr_o), 64'(NOP));
        check("rst_in_ready",  64'(in_ready_o), 64'd1);
        check("rst_stall",     64'(stall_cnt_o), 64'd0);
        check("rst_pc",        pc_o, 64'd0);

        // Back-to-back streaming, latency 1
        rst_i = 1'b0; out_ready_i = 1'b1;
        offer(64'h0, 32'hAAAA_0001); tick();
        check("stream_a", 64'(instr_o), 64'hAAAA_0001);
        offer(64'h4, 32'hBBBB_0002); tick();
        check("stream_b", 64'(instr_o), 64'hBBBB_0002);
        check("stream_b_pc", pc_o, 64'h4);
        offer(64'h8, 32'hCCCC_0003); tick();
        check("stream_c", 64'(instr_o), 64'hCCCC_0003);
        check("stream_c_valid", 64'(out_valid_o), 64'd1);
        in_valid_i = 1'b0; tick();
        check("drain_valid", 64'(out_valid_o), 64'd0);
        check("drain_nop",   64'(instr_o), 64'(NOP));
        check("drain_pc_hold", pc_o, 64'h8);

        // Back-pressure into the skid entry
        out_ready_i = 1'b0;
        offer(64'h10, 32'h1111_0010); tick();
        check("bp_a", 64'(instr_o), 64'h1111_0010);
        offer(64'h14, 32'h2222_0014); tick();
        check("bp_in_ready_low", 64'(in_ready_o), 64'd0);
        check("bp_a_held", 64'(instr_o), 64'h1111_0010);
        in_valid_i = 1'b0; tick();
        check("bp_still_full", 64'(in_ready_o), 64'd0);
        out_ready_i = 1'b1; tick();
        check("bp_b_out", 64'(instr_o), 64'h2222_0014);
        check("bp_b_pc", pc_o, 64'h14);
        check("bp_in_ready_back", 64'(in_ready_o), 64'd1);
        tick();
        check("bp_empty", 64'(out_valid_o), 64'd0);
        check("bp_stall", 64'(stall_cnt_o), 64'(stall_exp()));

        // Flush with M and S full and a new offer
        out_ready_i = 1'b0;
        offer(64'h20, 32'h3333_0020); tick();
        offer(64'h24, 32'h4444_0024); tick();
        check("fl_full", 64'(in_ready_o), 64'd0);
        flush_i = 1'b1;
        offer(64'h28, 32'h5555_0028); tick();
        check("fl_valid", 64'(out_valid_o), 64'd0);
        check("fl_nop",   64'(instr_o), 64'(NOP));
        check("fl_ready", 64'(in_ready_o), 64'd1);
        flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        tick();
        check("fl_c_dropped", 64'(out_valid_o), 64'd0);
        tick();
        check("fl_stall", 64'(stall_cnt_o), 64'(stall_exp()));

        // Stall counter over 5 back-pressured cycles from a clean reset
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        out_ready_i = 1'b0;
        offer(64'h30, 32'h6666_0030); tick();
        in_valid_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
`ifdef IF_ID_PERF_EN
        check("perf_5", 64'(stall_cnt_o), 64'd5);
`else
        check("perf_off", 64'(stall_cnt_o), 64'd0);
`endif
        check("perf_model", 64'(stall_cnt_o), 64'(stall_exp()));
        out_ready_i = 1'b1; tick();
        check("perf_drained", 64'(out_valid_o), 64'd0);

        // Reset beats flush and handshake with both entries full
        out_ready_i = 1'b0;
        offer(64'h40, 32'h7777_0040); tick();
        offer(64'h44, 32'h8888_0044); tick();
        check("mr_full", 64'(in_ready_o), 64'd0);
        rst_i = 1'b1; flush_i = 1'b1;
        offer(64'h48, 32'h9999_0048); tick();
        rst_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        check("mr_valid", 64'(out_valid_o), 64'd0);
        check("mr_ready", 64'(in_ready_o), 64'd1);
        check("mr_pc",    pc_o, 64'd0);
        check("mr_nop",   64'(instr_o), 64'(NOP));
        check("mr_stall", 64'(stall_cnt_o), 64'd0);
        tick();
        tick();
        check("mr_nothing_emitted", 64'(out_valid_o), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
